sif_wa_buffer: RTL and testbench
================================

# sif_wa_buffer

Downstream stage of the SIF slave: captures every write the slave emits on its write-out port (wa_wr_s / wa_addr / wa_data_wr) and queues it in a FIFO. The queue drains into the backing memory/register store through a valid/ready port. The wa side has no backpressure, so the block absorbs bursts and flags any write it has to drop.

## Interface
Parameters:
- DEPTH, 8, number of queued writes; power of two, ≥ 2
- AW, 16, address width (matches SIF wa_addr)
- DW, 16, data width (matches SIF wa_data_wr)

Ports:
- clk  in  1  single clock; all logic on rising edge
- rst_n  in  1  asynchronous, active-low reset
- wa_wr_s  in  1  write strobe from SIF slave, one write per high cycle
- wa_addr  in  AW  write address, sampled when wa_wr_s=1
- wa_data_wr  in  DW  write data, sampled when wa_wr_s=1
- m_valid  out  1  head entry available
- m_addr  out  AW  head address
- m_data  out  DW  head data
- m_ready  in  1  consumer accepts head this cycle
- level  out  $clog2(DEPTH)+1  entries currently stored
- full  out  1  level == DEPTH
- empty  out  1  level == 0
- ovf  out  1  sticky: at least one write dropped
- drop_cnt  out  8  dropped-write count, saturates at 255
- ovf_clr  in  1  clears ovf and drop_cnt

## Operation
- Storage: DEPTH × (AW+DW) array. Write and read pointers are $clog2(DEPTH) bits and wrap modulo DEPTH. level is a separate counter.
- pop = m_valid && m_ready. push = wa_wr_s && (!full || pop).
- Push writes {wa_addr, wa_data_wr} at wr_ptr, then wr_ptr++. Pop does rd_ptr++.
- level: +1 on push only, −1 on pop only, unchanged on both or neither.
- Full with simultaneous pop: the push is accepted, level stays DEPTH, nothing is dropped.
- Drop: wa_wr_s && full && !pop.
  - The write is discarded.
  - ovf <= 1.
  - drop_cnt <= min(drop_cnt+1, 255).
- ovf_clr: ovf <= 0, drop_cnt <= 0. If a drop occurs in the same cycle, the drop wins: ovf=1, drop_cnt=1.
- Empty with wa_wr_s: the entry is stored. No bypass to the m port in the same cycle.
- m_valid = !empty. m_addr and m_data are driven combinationally from array[rd_ptr] (first-word fall-through). When m_valid=0 they are don't-care and the bench must not check them.
- Consumer rule: once m_valid is high, m_addr and m_data stay stable until a pop. The block never retracts m_valid without a pop.
- No state machine beyond the pointer/counter logic. The ovf flag is a two-state (clear/set) register.

## Timing
- Reset (rst_n low, asynchronous):
  - pointers, level, drop_cnt = 0; ovf = 0
  - empty = 1, full = 0, m_valid = 0
  - array contents are not reset
- Reset released mid-traffic: all queued writes are lost. The first wa_wr_s after reset is stored at index 0.
- Latency: a write strobed in cycle k appears on m_valid/m_addr/m_data in cycle k+1 (one edge).
- Throughput: one push and one pop per cycle, sustained indefinitely at any level.
- level, full and empty are registered-state-derived. They update on the same edge as the pointers and reflect the post-edge state.
- ovf and drop_cnt update on the edge that ends the drop cycle.

## Structure
- Shared package sif_pkg holds:
  - localparams SIF_AW=16, SIF_DW=16
  - typedef struct packed {logic [SIF_AW-1:0] addr; logic [SIF_DW-1:0] data;} sif_wr_t
- The bench monitor reuses sif_wr_t for expected-queue entries.
- One sub-module: sif_fifo, a generic FWFT synchronous FIFO parameterised on WIDTH/DEPTH.
  - Ports: push, pop, wdata, rdata, level, full, empty.
- sif_wa_buffer wraps sif_fifo and adds the drop/ovf/drop_cnt logic and the sif_wr_t packing.

## Test plan
- Single write: wa_wr_s for 1 cycle with addr 0x0010, data 0xBEEF, m_ready=0 → next cycle m_valid=1, m_addr=0x0010, m_data=0xBEEF, level=1; these hold until m_ready=1 then empty=1.
- Fill and order: 8 back-to-back writes (addr i, data 0xA000+i), m_ready=0 → full=1, level=8; then m_ready=1 → pops emerge in order i=0..7, one per cycle, then empty=1.
- Overflow: with full=1 and m_ready=0, 3 extra writes → those 3 are dropped, ovf=1, drop_cnt=3, contents unchanged; ovf_clr → ovf=0, drop_cnt=0.
- Full with simultaneous push/pop: with full=1, m_ready=1 and wa_wr_s=1 for 20 cycles → no drops, level stays 8, output sequence is the original 8 followed by the new writes in order.
- Saturation and clear collision: 300 drops → drop_cnt=255. Then ovf_clr in the same cycle as a drop → ovf=1, drop_cnt=1.
- Async reset mid-operation: level=5, assert rst_n low between clock edges → empty=1, m_valid=0, level=0, ovf=0 immediately. After release, one write (0x0001, 0x1234) → m_addr=0x0001, m_data=0x1234.

Source files
------------

// File: rtl/sif_pkg.sv
// Shared SIF definitions: bus widths, the write-record layout and the
// encoding of the overflow flag.
package sif_pkg;

    localparam int unsigned SIF_AW = 16;
    localparam int unsigned SIF_DW = 16;

    typedef struct packed {
        logic [SIF_AW-1:0] addr;
        logic [SIF_DW-1:0] data;
    } sif_wr_t;

    localparam logic [0:0] OVF_CLEAR = 1'b0;
    localparam logic [0:0] OVF_SET   = 1'b1;

endpackage

// File: rtl/sif_wa_buffer_if.sv
// Write-capture side (wa_*) and downstream drain side (m_*) of the buffer.
interface sif_wa_buffer_if
    import sif_pkg::*;
#(
    parameter int unsigned AW = SIF_AW,
    parameter int unsigned DW = SIF_DW
);
    logic          wa_wr_s;
    logic [AW-1:0] wa_addr;
    logic [DW-1:0] wa_data_wr;
    logic          m_valid;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_data;
    logic          m_ready;

    modport slave (
        input  wa_wr_s, wa_addr, wa_data_wr, m_ready,
        output m_valid, m_addr, m_data
    );

    modport master (
        output wa_wr_s, wa_addr, wa_data_wr, m_ready,
        input  m_valid, m_addr, m_data
    );
endinterface

// File: rtl/sif_fifo.sv
// Generic first-word-fall-through synchronous FIFO; the caller guarantees
// push is never issued when full without a pop, and pop never when empty.
module sif_fifo #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         wdata,
    output logic [WIDTH-1:0]         rdata,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     full,
    output logic                     empty
);
    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned LW = PW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]    level_q, level_d;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (push) wr_ptr_d = wr_ptr_q + 1'b1;
        if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
        case ({push, pop})
            2'b10:   level_d = level_q + 1'b1;
            2'b01:   level_d = level_q - 1'b1;
            default: level_d = level_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    // Storage is deliberately not reset.
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= wdata;
    end

    assign rdata = mem_q[rd_ptr_q];
    assign level = level_q;
    assign full  = (level_q == LW'(DEPTH));
    assign empty = (level_q == '0);

endmodule

// File: rtl/sif_wa_buffer.sv
// Queues SIF slave writes for the backing store; the wa side cannot stall,
// so writes arriving while full (with no pop) are dropped and counted.
module sif_wa_buffer
    import sif_pkg::*;
#(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned AW    = SIF_AW,
    parameter int unsigned DW    = SIF_DW
) (
    input  logic                   clk,
    input  logic                   rst_n,
    sif_wa_buffer_if.slave         bus,
    output logic [$clog2(DEPTH):0] level,
    output logic                   full,
    output logic                   empty,
    output logic                   ovf,
    output logic [7:0]             drop_cnt,
    input  logic                   ovf_clr
);
    localparam int unsigned W = AW + DW;

    logic         push, pop, drop;
    logic         fifo_full, fifo_empty;
    logic [W-1:0] wdata, rdata;
    logic [0:0]   ovf_q, ovf_d;
    logic [7:0]   drop_cnt_q, drop_cnt_d;
    logic [7:0]   cnt_base;

    // A pop frees the slot in the same cycle, so a full queue still accepts.
    assign pop  = !fifo_empty && bus.m_ready;
    assign push = bus.wa_wr_s && (!fifo_full || pop);
    assign drop = bus.wa_wr_s && fifo_full && !pop;

    // Record layout {addr, data} matches sif_wr_t.
    assign wdata = {bus.wa_addr, bus.wa_data_wr};

    sif_fifo #(
        .WIDTH (W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .pop   (pop),
        .wdata (wdata),
        .rdata (rdata),
        .level (level),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign bus.m_valid            = !fifo_empty;
    assign {bus.m_addr, bus.m_data} = rdata;
    assign full                   = fifo_full;
    assign empty                  = fifo_empty;

    // Clear is applied first so a same-cycle drop restarts the count at 1.
    always_comb begin
        cnt_base   = ovf_clr ? '0 : drop_cnt_q;
        ovf_d      = ovf_clr ? OVF_CLEAR : ovf_q;
        drop_cnt_d = cnt_base;
        if (drop) begin
            ovf_d      = OVF_SET;
            drop_cnt_d = (&cnt_base) ? cnt_base : cnt_base + 8'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_q      <= OVF_CLEAR;
            drop_cnt_q <= '0;
        end else begin
            ovf_q      <= ovf_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    assign ovf      = (ovf_q == OVF_SET);
    assign drop_cnt = drop_cnt_q;

endmodule

// File: tb/tb_sif_wa_buffer.sv
// Scoreboard bench for sif_wa_buffer: queue-based reference model fed by the
// stimulus process, checked by an independent negedge monitor.
module tb_sif_wa_buffer;
    import sif_pkg::*;

    localparam int DEPTH = 8;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       ovf_clr;
    logic [3:0] level;
    logic       full, empty, ovf;
    logic [7:0] drop_cnt;

    sif_wa_buffer_if #(.AW(SIF_AW), .DW(SIF_DW)) ifc ();

    sif_wa_buffer #(
        .DEPTH (DEPTH),
        .AW    (SIF_AW),
        .DW    (SIF_DW)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .bus      (ifc.slave),
        .level    (level),
        .full     (full),
        .empty    (empty),
        .ovf      (ovf),
        .drop_cnt (drop_cnt),
        .ovf_clr  (ovf_clr)
    );

    always #5 clk = ~clk;

    int      n_cmp = 0;
    int      n_bad = 0;
    bit      mon_en = 1'b0;
    sif_wr_t exp_q[$];
    int      m_cnt  = 0;
    bit      m_ovf  = 1'b0;
    int      m_drop = 0;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: queue occupancy and drop bookkeeping from the rules.
    task automatic step(input bit wr, input logic [15:0] a, input logic [15:0] d,
                        input bit rdy, input bit clr);
        bit pop, push, drp;
        int nx_cnt, nx_drop;
        bit nx_ovf;
        ifc.wa_wr_s    = wr;
        ifc.wa_addr    = a;
        ifc.wa_data_wr = d;
        ifc.m_ready    = rdy;
        ovf_clr        = clr;
        pop  = (m_cnt > 0) && rdy;
        push = wr && ((m_cnt < DEPTH) || pop);
        drp  = wr && !push;
        nx_cnt  = m_cnt + (push ? 1 : 0) - (pop ? 1 : 0);
        nx_ovf  = m_ovf;
        nx_drop = m_drop;
        if (drp) begin
            nx_ovf  = 1'b1;
            nx_drop = clr ? 1 : ((m_drop < 255) ? m_drop + 1 : 255);
        end else if (clr) begin
            nx_ovf  = 1'b0;
            nx_drop = 0;
        end
        if (push) exp_q.push_back('{addr: a, data: d});
        @(posedge clk);
        #1;
        m_cnt  = nx_cnt;
        m_ovf  = nx_ovf;
        m_drop = nx_drop;
    endtask

    task automatic idle(input bit rdy);
        step(1'b0, 16'h0, 16'h0, rdy, 1'b0);
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            check("m_valid", ifc.m_valid, m_cnt > 0);
            check("level", level, m_cnt);
            check("full", full, m_cnt == DEPTH);
            check("empty", empty, m_cnt == 0);
            check("ovf", ovf, m_ovf);
            check("drop_cnt", drop_cnt, m_drop);
            if (m_cnt > 0 && exp_q.size() > 0) begin
                if (ifc.m_valid)
                    check("head", {ifc.m_addr, ifc.m_data}, exp_q[0]);
                if (ifc.m_ready) void'(exp_q.pop_front());
            end
        end
    end

    initial begin
        int rp;
        rst_n          = 1'b0;
        ifc.wa_wr_s    = 1'b0;
        ifc.wa_addr    = '0;
        ifc.wa_data_wr = '0;
        ifc.m_ready    = 1'b0;
        ovf_clr        = 1'b0;
        #12;
        check("rst_empty", empty, 1);
        check("rst_full", full, 0);
        check("rst_valid", ifc.m_valid, 0);
        check("rst_level", level, 0);
        check("rst_ovf", ovf, 0);
        check("rst_cnt", drop_cnt, 0);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk);
        #1;
        mon_en = 1'b1;

        // Single write held until accepted.
        step(1'b1, 16'h0010, 16'hBEEF, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) idle(1'b0);
        check("single_addr", ifc.m_addr, 16'h0010);
        check("single_data", ifc.m_data, 16'hBEEF);
        idle(1'b1);
        idle(1'b0);

        // Fill and ordered drain.
        for (int i = 0; i < 8; i++) step(1'b1, 16'(i), 16'(16'hA000 + i), 1'b0, 1'b0);
        check("fill_full", full, 1);
        for (int i = 0; i < 9; i++) idle(1'b1);

        // Overflow of 3, then clear.
        for (int i = 0; i < 8; i++) step(1'b1, 16'(16'h100 + i), 16'(16'hB000 + i), 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) step(1'b1, 16'hDEAD, 16'(i), 1'b0, 1'b0);
        check("ovf3_cnt", drop_cnt, 3);
        step(1'b0, 16'h0, 16'h0, 1'b0, 1'b1);
        check("ovf_clr_cnt", drop_cnt, 0);

        // Full with simultaneous push and pop.
        for (int i = 0; i < 20; i++) step(1'b1, 16'(16'h200 + i), 16'(16'hC000 + i), 1'b1, 1'b0);
        check("pp_level", level, 8);
        check("pp_cnt", drop_cnt, 0);
        for (int i = 0; i < 9; i++) idle(1'b1);

        // Saturation, then clear colliding with a drop.
        for (int i = 0; i < 8; i++) step(1'b1, 16'(16'h300 + i), 16'(i), 1'b0, 1'b0);
        for (int i = 0; i < 300; i++) step(1'b1, 16'hFFFF, 16'(i), 1'b0, 1'b0);
        check("sat_cnt", drop_cnt, 255);
        step(1'b1, 16'hFFFF, 16'hFFFF, 1'b0, 1'b1);
        check("clr_win_ovf", ovf, 1);
        check("clr_win_cnt", drop_cnt, 1);
        for (int i = 0; i < 9; i++) idle(1'b1);
        step(1'b0, 16'h0, 16'h0, 1'b0, 1'b1);

        // Async reset with level 5 and ovf set.
        for (int i = 0; i < 9; i++) step(1'b1, 16'(16'h400 + i), 16'(i), 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) idle(1'b1);
        check("pre_rst_level", level, 5);
        #2;
        mon_en         = 1'b0;
        ifc.m_ready    = 1'b0;
        ifc.wa_wr_s    = 1'b0;
        rst_n          = 1'b0;
        #1;
        check("arst_empty", empty, 1);
        check("arst_valid", ifc.m_valid, 0);
        check("arst_level", level, 0);
        check("arst_ovf", ovf, 0);
        exp_q.delete();
        m_cnt  = 0;
        m_ovf  = 1'b0;
        m_drop = 0;
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk);
        #1;
        mon_en = 1'b1;
        step(1'b1, 16'h0001, 16'h1234, 1'b0, 1'b0);
        idle(1'b0);
        check("post_rst_addr", ifc.m_addr, 16'h0001);
        check("post_rst_data", ifc.m_data, 16'h1234);
        idle(1'b1);

        // Randomised traffic with varying consumer rate.
        rp = 50;
        for (int i = 0; i < 3000; i++) begin
            if (i % 200 == 0) rp = $urandom_range(100);
            step($urandom_range(99) < 70, 16'($urandom), 16'($urandom),
                 $urandom_range(99) < rp, $urandom_range(99) < 3);
        end
        for (int i = 0; i < 10; i++) step(1'b0, 16'h0, 16'h0, 1'b1, 1'b1);
        check("final_empty", empty, 1);

        mon_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
